// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the MEM/WB writeback stage: widths, writeback select codes, FSM states.
package writeback_stage_pkg;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC  = 2'd2,
      WB_RSV = 2'd3
   } wb_sel_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_e;
endpackage

// File: rtl/writeback_stage_if.sv
// MEM-side inputs and register-file/forwarding outputs of the writeback stage.
interface writeback_stage_if #(
   parameter int unsigned DATA_W = writeback_stage_pkg::DATA_W,
   parameter int unsigned REG_W  = writeback_stage_pkg::REG_W,
   parameter int unsigned CNT_W  = writeback_stage_pkg::CNT_W
);
   logic              stall;
   logic              flush;
   logic              mem_valid;
   logic [REG_W-1:0]  mem_DstReg;
   logic              mem_WriteReg;
   logic [1:0]        mem_wb_sel;
   logic [DATA_W-1:0] mem_AluOut;
   logic [DATA_W-1:0] mem_MemData;
   logic [DATA_W-1:0] mem_PcPlus2;
   logic              mem_halt;
   logic [REG_W-1:0]  DstReg;
   logic              WriteReg;
   logic [DATA_W-1:0] DstData;
   logic              wb_fwd_valid;
   logic              halt;
   logic [CNT_W-1:0]  retired;

   modport master (
      output stall, flush, mem_valid, mem_DstReg, mem_WriteReg, mem_wb_sel,
             mem_AluOut, mem_MemData, mem_PcPlus2, mem_halt,
      input  DstReg, WriteReg, DstData, wb_fwd_valid, halt, retired
   );

   modport slave (
      input  stall, flush, mem_valid, mem_DstReg, mem_WriteReg, mem_wb_sel,
             mem_AluOut, mem_MemData, mem_PcPlus2, mem_halt,
      output DstReg, WriteReg, DstData, wb_fwd_valid, halt, retired
   );
endinterface

// File: rtl/writeback_stage_wb_mux.sv
// 3:1 writeback value select; a bubble produces zero.
module wb_mux
   import writeback_stage_pkg::*;
#(
   parameter int unsigned DATA_W = writeback_stage_pkg::DATA_W
) (
   input  logic              valid,
   input  wb_sel_e           sel,
   input  logic [DATA_W-1:0] alu,
   input  logic [DATA_W-1:0] mem,
   input  logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] data
);
   always_comb begin
      data = '0;
      if (valid) begin
         case (sel)
            WB_MEM:  data = mem;
            WB_PC:   data = pc;
            default: data = alu;
         endcase
      end
   end
endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback mux, halt retirement and retired-instruction counter.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int unsigned DATA_W = writeback_stage_pkg::DATA_W,
   parameter int unsigned REG_W  = writeback_stage_pkg::REG_W,
   parameter int unsigned CNT_W  = writeback_stage_pkg::CNT_W
) (
   input logic             clk,
   input logic             rst,
   writeback_stage_if.slave bus
);
   logic              wb_valid;
   logic [REG_W-1:0]  wb_DstReg;
   logic              wb_WriteReg;
   wb_sel_e           wb_sel;
   logic [DATA_W-1:0] wb_AluOut;
   logic [DATA_W-1:0] wb_MemData;
   logic [DATA_W-1:0] wb_PcPlus2;
   logic              wb_halt;
   logic              written;
   state_e            state;
   logic              halt_q;
   logic [CNT_W-1:0]  retired_q;

   logic              write_en;
   logic              retire_now;
   logic              halt_now;

   // written keeps a stalled entry from writing or counting more than once
   always_comb begin
      write_en   = wb_valid & wb_WriteReg & ~wb_halt & (wb_DstReg != '0)
                   & ~written & (state != HALTED);
      retire_now = wb_valid & ~wb_halt & ~written & (state != HALTED);
      halt_now   = wb_valid & wb_halt & ~written & (state != HALTED);
   end

   always_ff @(posedge clk) begin
      if (!rst || bus.flush) begin
         wb_valid    <= 1'b0;
         wb_DstReg   <= '0;
         wb_WriteReg <= 1'b0;
         wb_sel      <= WB_ALU;
         wb_AluOut   <= '0;
         wb_MemData  <= '0;
         wb_PcPlus2  <= '0;
         wb_halt     <= 1'b0;
         written     <= 1'b0;
      end else if (bus.stall) begin
         written     <= written | write_en | retire_now;
      end else begin
         wb_valid    <= bus.mem_valid;
         wb_DstReg   <= bus.mem_DstReg;
         wb_WriteReg <= bus.mem_WriteReg;
         wb_sel      <= wb_sel_e'(bus.mem_wb_sel);
         wb_AluOut   <= bus.mem_AluOut;
         wb_MemData  <= bus.mem_MemData;
         wb_PcPlus2  <= bus.mem_PcPlus2;
         wb_halt     <= bus.mem_halt;
         written     <= 1'b0;
      end
   end

   // A HLT arriving as the very first instruction halts straight from IDLE
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         halt_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         if (retire_now && (retired_q != '1))
            retired_q <= retired_q + CNT_W'(1);
         case (state)
            IDLE: begin
               if (halt_now) begin
                  state  <= HALTED;
                  halt_q <= 1'b1;
               end else if (wb_valid) begin
                  state  <= RUN;
               end
            end
            RUN: begin
               if (halt_now) begin
                  state  <= HALTED;
                  halt_q <= 1'b1;
               end
            end
            HALTED:  halt_q <= 1'b1;
            default: state  <= IDLE;
         endcase
      end
   end

   wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
      .valid (wb_valid),
      .sel   (wb_sel),
      .alu   (wb_AluOut),
      .mem   (wb_MemData),
      .pc    (wb_PcPlus2),
      .data  (bus.DstData)
   );

   assign bus.DstReg       = wb_DstReg;
   assign bus.WriteReg     = write_en;
   assign bus.wb_fwd_valid = write_en;
   assign bus.halt         = halt_q;
   assign bus.retired      = retired_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic vs a model.
module tb_writeback_stage;
   logic clk;
   logic rst;
   int unsigned n_tests;
   int unsigned n_fail;

   writeback_stage_if bus ();

   writeback_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction-level model: the entry sitting in WB, whether it already took effect,
   // whether the processor has halted, and how many instructions retired.
   typedef struct packed {
      bit        v;
      bit [3:0]  dst;
      bit        we;
      bit [1:0]  sel;
      bit [15:0] alu;
      bit [15:0] md;
      bit [15:0] pc;
      bit        hlt;
   } ent_t;

   ent_t        m_e;
   bit          m_done;
   bit          m_halted;
   int unsigned m_cnt;

   function automatic bit exp_we();
      return m_e.v && m_e.we && !m_e.hlt && (m_e.dst != 4'd0) && !m_done && !m_halted;
   endfunction

   function automatic bit [15:0] exp_data();
      if (!m_e.v) return 16'h0000;
      if (m_e.sel == 2'd1) return m_e.md;
      if (m_e.sel == 2'd2) return m_e.pc;
      return m_e.alu;
   endfunction

   task automatic drive(input bit v, input bit [3:0] d, input bit we, input bit [1:0] sel,
                        input bit [15:0] alu, input bit [15:0] md, input bit [15:0] pc,
                        input bit h, input bit st, input bit fl);
      bus.mem_valid    = v;
      bus.mem_DstReg   = d;
      bus.mem_WriteReg = we;
      bus.mem_wb_sel   = sel;
      bus.mem_AluOut   = alu;
      bus.mem_MemData  = md;
      bus.mem_PcPlus2  = pc;
      bus.mem_halt     = h;
      bus.stall        = st;
      bus.flush        = fl;
   endtask

   task automatic idle();
      drive(0, 4'd0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 0, 0, 0);
   endtask

   // One clock: capture what the DUT sees, advance the model, return at the falling edge.
   task automatic tick();
      ent_t inc;
      bit r, f, s, did_retire, did_halt;
      inc.v = bus.mem_valid;  inc.dst = bus.mem_DstReg; inc.we = bus.mem_WriteReg;
      inc.sel = bus.mem_wb_sel; inc.alu = bus.mem_AluOut; inc.md = bus.mem_MemData;
      inc.pc = bus.mem_PcPlus2; inc.hlt = bus.mem_halt;
      r = rst; f = bus.flush; s = bus.stall;
      @(posedge clk);
      did_retire = m_e.v && !m_e.hlt && !m_done && !m_halted;
      did_halt   = m_e.v && m_e.hlt && !m_done && !m_halted;
      if (!r) begin
         m_e = '0; m_done = 0; m_halted = 0; m_cnt = 0;
      end else begin
         if (did_retire && m_cnt < 65535) m_cnt++;
         if (did_halt) m_halted = 1;
         if (f) begin
            m_e = '0; m_done = 0;
         end else if (s) begin
            m_done = m_done | did_retire;
         end else begin
            m_e = inc; m_done = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_tests++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", bus.WriteReg); end
      n_tests++; if (bus.DstReg !== 4'd0) begin n_fail++; $display("FAIL reset_dst: got %0d want 0", bus.DstReg); end
      n_tests++; if (bus.DstData !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", bus.DstData); end
      n_tests++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %0b want 0", bus.halt); end
      n_tests++; if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
   endtask

   task automatic test_alu();
      drive(1, 4'd3, 1, 2'd0, 16'h1234, 16'hAAAA, 16'h5555, 0, 0, 0);
      tick();
      idle();
      n_tests++; if (bus.WriteReg !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %0b want 1", bus.WriteReg); end
      n_tests++; if (bus.wb_fwd_valid !== 1'b1) begin n_fail++; $display("FAIL alu_fwd: got %0b want 1", bus.wb_fwd_valid); end
      n_tests++; if (bus.DstReg !== 4'd3) begin n_fail++; $display("FAIL alu_dst: got %0d want 3", bus.DstReg); end
      n_tests++; if (bus.DstData !== 16'h1234) begin n_fail++; $display("FAIL alu_data: got %h want 1234", bus.DstData); end
      tick();
      n_tests++; if (bus.retired !== 16'd1) begin n_fail++; $display("FAIL alu_retired: got %0d want 1", bus.retired); end
   endtask

   task automatic test_load_r0();
      drive(1, 4'd0, 1, 2'd1, 16'h1111, 16'hBEEF, 16'h2222, 0, 0, 0);
      tick();
      idle();
      n_tests++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL r0_we: got %0b want 0", bus.WriteReg); end
      n_tests++; if (bus.DstData !== 16'hBEEF) begin n_fail++; $display("FAIL r0_data: got %h want beef", bus.DstData); end
      tick();
      n_tests++; if (bus.retired !== 16'd2) begin n_fail++; $display("FAIL r0_retired: got %0d want 2", bus.retired); end
   endtask

   task automatic test_stall();
      drive(1, 4'd5, 1, 2'd2, 16'h0101, 16'h0202, 16'h0042, 0, 0, 0);
      tick();
      n_tests++; if (bus.WriteReg !== 1'b1) begin n_fail++; $display("FAIL stall_first_we: got %0b want 1", bus.WriteReg); end
      n_tests++; if (bus.DstData !== 16'h0042) begin n_fail++; $display("FAIL stall_first_data: got %h want 0042", bus.DstData); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'd9, 1, 2'd0, 16'hDEAD, 16'h0, 16'h0, 0, 1, 0);
         tick();
         n_tests++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL stall_we[%0d]: got %0b want 0", i, bus.WriteReg); end
         n_tests++; if (bus.DstReg !== 4'd5) begin n_fail++; $display("FAIL stall_dst[%0d]: got %0d want 5", i, bus.DstReg); end
         n_tests++; if (bus.DstData !== 16'h0042) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want 0042", i, bus.DstData); end
         n_tests++; if (bus.retired !== 16'd3) begin n_fail++; $display("FAIL stall_retired[%0d]: got %0d want 3", i, bus.retired); end
      end
      idle();
      tick();
      n_tests++; if (bus.retired !== 16'd3) begin n_fail++; $display("FAIL stall_after_retired: got %0d want 3", bus.retired); end
   endtask

   task automatic test_flush_stall();
      drive(1, 4'd7, 1, 2'd0, 16'h5555, 16'h0, 16'h0, 0, 0, 0);
      tick();
      drive(1, 4'd6, 1, 2'd0, 16'h7777, 16'h0, 16'h0, 0, 1, 1);
      tick();
      idle();
      n_tests++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL flush_we: got %0b want 0", bus.WriteReg); end
      n_tests++; if (bus.wb_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_fwd: got %0b want 0", bus.wb_fwd_valid); end
      n_tests++; if (bus.DstData !== 16'h0) begin n_fail++; $display("FAIL flush_data: got %h want 0000", bus.DstData); end
      n_tests++; if (bus.retired !== 16'd4) begin n_fail++; $display("FAIL flush_retired: got %0d want 4", bus.retired); end
      tick();
      n_tests++; if (bus.retired !== 16'd4) begin n_fail++; $display("FAIL flush_bubble_retired: got %0d want 4", bus.retired); end
   endtask

   task automatic test_halt();
      drive(1, 4'd0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 1, 0, 0);
      tick();
      n_tests++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL hlt_we: got %0b want 0", bus.WriteReg); end
      n_tests++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL hlt_early: got %0b want 0", bus.halt); end
      drive(1, 4'd2, 1, 2'd0, 16'h2222, 16'h0, 16'h0, 0, 0, 0);
      tick();
      idle();
      n_tests++; if (bus.halt !== 1'b1) begin n_fail++; $display("FAIL hlt_halt: got %0b want 1", bus.halt); end
      n_tests++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL hlt_add_we: got %0b want 0", bus.WriteReg); end
      tick();
      n_tests++; if (bus.halt !== 1'b1) begin n_fail++; $display("FAIL hlt_sticky: got %0b want 1", bus.halt); end
      n_tests++; if (bus.retired !== 16'd4) begin n_fail++; $display("FAIL hlt_retired: got %0d want 4", bus.retired); end
   endtask

   task automatic test_reset_in_halt();
      drive(1, 4'd4, 1, 2'd0, 16'h4444, 16'h0, 16'h0, 0, 1, 0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      idle();
      n_tests++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL rsthalt_halt: got %0b want 0", bus.halt); end
      n_tests++; if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL rsthalt_retired: got %0d want 0", bus.retired); end
      n_tests++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL rsthalt_we: got %0b want 0", bus.WriteReg); end
      drive(1, 4'd1, 1, 2'd0, 16'h0ABC, 16'h0, 16'h0, 0, 0, 0);
      tick();
      idle();
      n_tests++; if (bus.WriteReg !== 1'b1) begin n_fail++; $display("FAIL rsthalt_resume_we: got %0b want 1", bus.WriteReg); end
      n_tests++; if (bus.DstData !== 16'h0ABC) begin n_fail++; $display("FAIL rsthalt_resume_data: got %h want 0abc", bus.DstData); end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 49) != 0);
         tick();
         n_tests++; if (bus.WriteReg !== exp_we()) begin n_fail++; $display("FAIL rnd_we[%0d]: got %0b want %0b", i, bus.WriteReg, exp_we()); end
         n_tests++; if (bus.wb_fwd_valid !== exp_we()) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got %0b want %0b", i, bus.wb_fwd_valid, exp_we()); end
         n_tests++; if (bus.DstData !== exp_data()) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, bus.DstData, exp_data()); end
         n_tests++; if (bus.halt !== m_halted) begin n_fail++; $display("FAIL rnd_halt[%0d]: got %0b want %0b", i, bus.halt, m_halted); end
         n_tests++; if (bus.retired !== m_cnt[15:0]) begin n_fail++; $display("FAIL rnd_retired[%0d]: got %0d want %0d", i, bus.retired, m_cnt); end
         if (m_e.v) begin
            n_tests++; if (bus.DstReg !== m_e.dst) begin n_fail++; $display("FAIL rnd_dst[%0d]: got %0d want %0d", i, bus.DstReg, m_e.dst); end
         end
      end
      rst = 1'b1;
      idle();
   endtask

   task automatic test_saturate();
      idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      while (m_cnt < 65534) begin
         drive(1, 4'($urandom_range(1, 15)), 1, 2'd0, 16'($urandom), 16'h0, 16'h0, 0, 0, 0);
         tick();
      end
      n_tests++; if (bus.retired !== 16'hFFFE) begin n_fail++; $display("FAIL sat_near: got %h want fffe", bus.retired); end
      for (int i = 0; i < 4; i++) begin
         drive(1, 4'd8, 1, 2'd0, 16'h8888, 16'h0, 16'h0, 0, 0, 0);
         tick();
      end
      idle();
      n_tests++; if (bus.retired !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", bus.retired); end
      n_tests++; if (bus.WriteReg !== 1'b1) begin n_fail++; $display("FAIL sat_we: got %0b want 1", bus.WriteReg); end
      tick();
      n_tests++; if (bus.retired !== 16'hFFFF) begin n_fail++; $display("FAIL sat_nowrap: got %h want ffff", bus.retired); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      m_e = '0; m_done = 0; m_halted = 0; m_cnt = 0;
      rst = 1'b0;
      idle();
      @(negedge clk);
      test_reset();
      test_alu();
      test_load_r0();
      test_stall();
      test_flush_stall();
      test_halt();
      test_reset_in_halt();
      test_random();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
